mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single synchronous memory port (ROM/RAM/IO map) between two requesters.
//  Requester 0 is the CPU bus interface; requester 1 is the program loader / debug port.
//  Each transfer is one byte, read or write. The winning request is latched, driven to memory and completed with a 1-cycle ack.
//  Sits between the CPU datapath/MAR and the memory system; the rest of the computer sees one memory master at a time.
// PARAMETERS
//  ADDR_W    8  address width (mem_address, cpu_addr, dbg_addr)
//  DATA_W    8  data width (all data buses)
//  READ_LAT  1  memory cycles from address cycle to valid mem_to_bus; legal 1..4, other values -> $error at elaboration
// PORTS
//  Clk           in   1       system clock; all state changes on rising edge
//  Reset         in   1       asynchronous, active-low reset
//  cpu_req       in   1       CPU requests a transfer; sampled only in IDLE
//  cpu_we        in   1       1=write, 0=read; latched at grant
//  cpu_addr      in   ADDR_W  transfer address; latched at grant
//  cpu_wdata     in   DATA_W  write data; latched at grant
//  cpu_gnt       out  1       CPU owns memory (ADDR..DONE inclusive)
//  cpu_ack       out  1       1-cycle pulse: CPU transfer complete; cpu_rdata valid for reads
//  cpu_rdata     out  DATA_W  read data; held until the next CPU read ack
//  dbg_req/dbg_we/dbg_addr/dbg_wdata  in   same as cpu_*, requester 1
//  dbg_gnt/dbg_ack/dbg_rdata          out  same as cpu_*, requester 1
//  mem_address   out  ADDR_W  address to memory, registered
//  mem_from_bus  out  DATA_W  write data to memory, registered
//  mem_write     out  1       memory write strobe, registered
//  mem_to_bus    in   DATA_W  read data from memory
//  busy          out  1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, Reset=0): state=IDLE; all gnt/ack/mem_write/busy=0.
//   mem_address, mem_from_bus, cpu_rdata and dbg_rdata=0; last_winner=dbg.
//   Mid-transfer reset aborts immediately. No ack is issued; mem_write drops the same instant.
//  FSM: IDLE -> ADDR -> (write) DONE | (read) WAIT -> DONE -> IDLE.
//  IDLE: if any req, choose winner, latch we/addr/wdata, assert winner gnt -> ADDR. Else stay; outputs hold.
//  ADDR (1 cycle): mem_address/mem_from_bus = latched values; mem_write = latched we.
//   Write -> DONE. Read -> WAIT with cnt=READ_LAT.
//  WAIT: cnt decrements each cycle. Last WAIT cycle captures mem_to_bus into winner rdata -> DONE.
//   WAIT lasts exactly READ_LAT cycles.
//  DONE (1 cycle): winner ack=1, gnt stays 1; gnt drops on exit -> IDLE.
//  Latency, req seen in IDLE cycle 0:
//   gnt in cycle 1.
//   Write: ack in cycle 2 (3 cycles per transfer).
//   Read: ack in cycle 2+READ_LAT.
//  mem_write is high only in a write ADDR cycle; never in IDLE/WAIT/DONE.
//  mem_address holds its last value outside ADDR.
//  Requester inputs change after grant: ignored. Latched copy is used.
//  req dropped after grant: transfer still completes and acks.
//  Loser of a simultaneous request keeps req high; it is served on a later IDLE.
//  Non-winner outputs stay 0 throughout; the non-winner rdata is never modified.
//  Fixed priority (default): CPU wins when both request; dbg can starve (accepted).
//  last_winner is updated at every grant.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: simultaneous requests go to the requester that is not last_winner.
//   Single requests are unaffected. No starvation; worst-case dbg wait is one CPU transfer.
//  Undefined: fixed CPU priority as above; last_winner is still maintained but unused.
// TESTING
//  1. CPU write addr=8'h80 data=8'h5A -> gnt cycle 1; mem_write=1 only in cycle 1 with mem_address=80, mem_from_bus=5A; cpu_ack cycle 2.
//  2. dbg read addr=8'h10, model returns 8'hC3, READ_LAT=1 and 3 -> dbg_ack cycles 3 and 5; dbg_rdata=C3; cpu_* unchanged.
//  3. Both req held continuously, 4 transfers -> fixed: CPU,CPU,CPU,CPU; with macro: CPU,dbg,CPU,dbg; never both gnt=1.
//  4. Change cpu_addr 8'h20->8'h21 and drop cpu_req in cycle 1 of a write -> mem_address=20; ack still pulses.
//  5. Reset=0 during WAIT -> all outputs zero asynchronously; no ack; after release a new req completes normally from IDLE.
//  6. Back-to-back CPU writes, req held high -> ack every 3 cycles, busy low exactly 1 cycle between transfers.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester (CPU / debug loader) arbiter for one synchronous byte-wide memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for alternating priority on simultaneous requests; default is fixed CPU priority.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_from_bus,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_to_bus,
    output logic              busy
);

    generate
        if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
            $error("mem_bus_arbiter: READ_LAT must be in 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic              win_reg, win_next;          // 1 = debug port owns the transfer
    logic              last_winner_reg, last_winner_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              mem_write_reg, mem_write_next;
    logic              cpu_gnt_reg, cpu_gnt_next;
    logic              dbg_gnt_reg, dbg_gnt_next;
    logic              cpu_ack_reg, cpu_ack_next;
    logic              dbg_ack_reg, dbg_ack_next;
    logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
    logic [DATA_W-1:0] dbg_rdata_reg, dbg_rdata_next;
    logic              pick_dbg;

    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie the requester that did not win last time gets the bus.
        pick_dbg = dbg_req && (!cpu_req || !last_winner_reg);
`else
        pick_dbg = dbg_req && !cpu_req;
`endif
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            win_reg         <= 1'b0;
            last_winner_reg <= 1'b1;
            we_reg          <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            mem_write_reg   <= 1'b0;
            cpu_gnt_reg     <= 1'b0;
            dbg_gnt_reg     <= 1'b0;
            cpu_ack_reg     <= 1'b0;
            dbg_ack_reg     <= 1'b0;
            cpu_rdata_reg   <= '0;
            dbg_rdata_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            win_reg         <= win_next;
            last_winner_reg <= last_winner_next;
            we_reg          <= we_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            mem_write_reg   <= mem_write_next;
            cpu_gnt_reg     <= cpu_gnt_next;
            dbg_gnt_reg     <= dbg_gnt_next;
            cpu_ack_reg     <= cpu_ack_next;
            dbg_ack_reg     <= dbg_ack_next;
            cpu_rdata_reg   <= cpu_rdata_next;
            dbg_rdata_reg   <= dbg_rdata_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        win_next         = win_reg;
        last_winner_next = last_winner_reg;
        we_next          = we_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        mem_write_next   = 1'b0;
        cpu_gnt_next     = cpu_gnt_reg;
        dbg_gnt_next     = dbg_gnt_reg;
        cpu_ack_next     = 1'b0;
        dbg_ack_next     = 1'b0;
        cpu_rdata_next   = cpu_rdata_reg;
        dbg_rdata_next   = dbg_rdata_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    // Memory-side registers load at the grant edge so ADDR drives them directly.
                    win_next         = pick_dbg;
                    last_winner_next = pick_dbg;
                    we_next          = pick_dbg ? dbg_we    : cpu_we;
                    addr_next        = pick_dbg ? dbg_addr  : cpu_addr;
                    wdata_next       = pick_dbg ? dbg_wdata : cpu_wdata;
                    mem_write_next   = pick_dbg ? dbg_we    : cpu_we;
                    cpu_gnt_next     = !pick_dbg;
                    dbg_gnt_next     = pick_dbg;
                    state_next       = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (we_reg) begin
                    cpu_ack_next = !win_reg;
                    dbg_ack_next = win_reg;
                    state_next   = ST_DONE;
                end else begin
                    cnt_next   = 3'(READ_LAT);
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 3'd1;
                if (cnt_reg == 3'd1) begin
                    if (win_reg) begin
                        dbg_rdata_next = mem_to_bus;
                        dbg_ack_next   = 1'b1;
                    end else begin
                        cpu_rdata_next = mem_to_bus;
                        cpu_ack_next   = 1'b1;
                    end
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                cpu_gnt_next = 1'b0;
                dbg_gnt_next = 1'b0;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cpu_gnt      = cpu_gnt_reg;
    assign dbg_gnt      = dbg_gnt_reg;
    assign cpu_ack      = cpu_ack_reg;
    assign dbg_ack      = dbg_ack_reg;
    assign cpu_rdata    = cpu_rdata_reg;
    assign dbg_rdata    = dbg_rdata_reg;
    assign mem_address  = addr_reg;
    assign mem_from_bus = wdata_reg;
    assign mem_write    = mem_write_reg;
    assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic vs. a transaction-level model.
module tb_mem_bus_arbiter;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic       en3;
    logic       load_mem;

    logic       cpu_gnt, cpu_ack, dbg_gnt, dbg_ack, mem_write, busy;
    logic [7:0] cpu_rdata, dbg_rdata, mem_address, mem_from_bus, mem_to_bus;
    logic       cpu_gnt_3, cpu_ack_3, dbg_gnt_3, dbg_ack_3, mem_write_3, busy_3;
    logic [7:0] cpu_rdata_3, dbg_rdata_3, mem_address_3, mem_from_bus_3, mem_to_bus_3;

    logic [7:0] seed_mem [256];
    logic [7:0] mem1 [256];
    logic [7:0] mem3 [256];
    logic [7:0] pipe3 [3];

    logic [7:0] ref_mem [256];
    logic [7:0] exp_rd [2];
    bit         lw_dbg;
    int         pass_cnt = 0;
    int         total    = 0;

    always #5 Clk = ~Clk;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1)) dut1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_address(mem_address), .mem_from_bus(mem_from_bus), .mem_write(mem_write),
        .mem_to_bus(mem_to_bus), .busy(busy)
    );

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(3)) dut3 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req & en3), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_3), .cpu_ack(cpu_ack_3), .cpu_rdata(cpu_rdata_3),
        .dbg_req(dbg_req & en3), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt_3), .dbg_ack(dbg_ack_3), .dbg_rdata(dbg_rdata_3),
        .mem_address(mem_address_3), .mem_from_bus(mem_from_bus_3), .mem_write(mem_write_3),
        .mem_to_bus(mem_to_bus_3), .busy(busy_3)
    );

    // Synchronous memories: one registered stage for dut1, three for dut3.
    always @(posedge Clk) begin
        if (load_mem) begin
            for (int i = 0; i < 256; i++) begin
                mem1[i] <= seed_mem[i];
                mem3[i] <= seed_mem[i];
            end
        end else begin
            if (mem_write)   mem1[mem_address]   <= mem_from_bus;
            if (mem_write_3) mem3[mem_address_3] <= mem_from_bus_3;
        end
        mem_to_bus <= mem1[mem_address];
        pipe3[0]   <= mem3[mem_address_3];
        pipe3[1]   <= pipe3[0];
        pipe3[2]   <= pipe3[1];
    end
    assign mem_to_bus_3 = pipe3[2];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic bit pick(input bit c, input bit d);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return (c && d) ? !lw_dbg : d;
`else
        return d && !c;
`endif
    endfunction

    // Caller has raised the request(s) during an IDLE cycle (cycle 0); returns in the ack cycle.
    task automatic xfer_check(input string tag, input bit who, input bit we,
                              input logic [7:0] addr, input logic [7:0] wdata, input bit drop);
        int         ack_at;
        logic [7:0] exp_data;
        logic [1:0] exp_gnt;
        ack_at   = we ? 2 : 3;
        exp_data = ref_mem[addr];
        exp_gnt  = who ? 2'b10 : 2'b01;
        for (int c = 1; c <= ack_at; c++) begin
            step();
            total++; if ({dbg_gnt, cpu_gnt} !== exp_gnt) $display("FAIL %s gnt c%0d: got %b want %b", tag, c, {dbg_gnt, cpu_gnt}, exp_gnt); else pass_cnt++;
            total++; if ({dbg_ack, cpu_ack} !== ((c == ack_at) ? exp_gnt : 2'b00)) $display("FAIL %s ack c%0d: got %b", tag, c, {dbg_ack, cpu_ack}); else pass_cnt++;
            total++; if (mem_write !== (c == 1 && we)) $display("FAIL %s mem_write c%0d: got %b want %b", tag, c, mem_write, (c == 1 && we)); else pass_cnt++;
            total++; if (busy !== 1'b1) $display("FAIL %s busy c%0d: got %b want 1", tag, c, busy); else pass_cnt++;
            total++; if (mem_address !== addr) $display("FAIL %s mem_address c%0d: got %h want %h", tag, c, mem_address, addr); else pass_cnt++;
            if (c == 1 && we) begin
                total++; if (mem_from_bus !== wdata) $display("FAIL %s mem_from_bus: got %h want %h", tag, mem_from_bus, wdata); else pass_cnt++;
            end
        end
        if (we) ref_mem[addr] = wdata;
        else    exp_rd[who]   = exp_data;
        lw_dbg = who;
        total++; if (cpu_rdata !== exp_rd[0]) $display("FAIL %s cpu_rdata: got %h want %h", tag, cpu_rdata, exp_rd[0]); else pass_cnt++;
        total++; if (dbg_rdata !== exp_rd[1]) $display("FAIL %s dbg_rdata: got %h want %h", tag, dbg_rdata, exp_rd[1]); else pass_cnt++;
        if (drop) begin
            if (who) dbg_req = 1'b0;
            else     cpu_req = 1'b0;
        end
        $display("xfer %s: %s %s addr=%h data=%h", tag, who ? "dbg" : "cpu", we ? "WR" : "RD", addr, we ? wdata : exp_data);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #1;
        total++; if ({cpu_gnt, dbg_gnt, cpu_ack, dbg_ack, mem_write, busy} !== 6'b0) $display("FAIL reset ctl1: got %b want 0", {cpu_gnt, dbg_gnt, cpu_ack, dbg_ack, mem_write, busy}); else pass_cnt++;
        total++; if ({cpu_gnt_3, dbg_gnt_3, cpu_ack_3, dbg_ack_3, mem_write_3, busy_3} !== 6'b0) $display("FAIL reset ctl3: got %b want 0", {cpu_gnt_3, dbg_gnt_3, cpu_ack_3, dbg_ack_3, mem_write_3, busy_3}); else pass_cnt++;
        total++; if ({mem_address, mem_from_bus, cpu_rdata, dbg_rdata} !== 32'h0) $display("FAIL reset data1: got %h want 0", {mem_address, mem_from_bus, cpu_rdata, dbg_rdata}); else pass_cnt++;
        total++; if ({mem_address_3, mem_from_bus_3, cpu_rdata_3, dbg_rdata_3} !== 32'h0) $display("FAIL reset data3: got %h want 0", {mem_address_3, mem_from_bus_3, cpu_rdata_3, dbg_rdata_3}); else pass_cnt++;
        lw_dbg = 1'b1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        load_mem = 1'b0;
        Reset    = 1'b1;
        step();
    endtask

    task automatic test_cpu_write();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h80; cpu_wdata = 8'h5A;
        xfer_check("cpu_write", 1'b0, 1'b1, 8'h80, 8'h5A, 1'b1);
        step();
        total++; if ({cpu_gnt, cpu_ack, busy, mem_write} !== 4'b0) $display("FAIL cpu_write idle: got %b want 0000", {cpu_gnt, cpu_ack, busy, mem_write}); else pass_cnt++;
    endtask

    task automatic test_dbg_read_latency();
        en3 = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h10; dbg_wdata = 8'hEE;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) dbg_req = 1'b0;
            total++; if (dbg_ack !== (c == 3)) $display("FAIL dbg_read lat1 ack c%0d: got %b want %b", c, dbg_ack, (c == 3)); else pass_cnt++;
            total++; if (dbg_ack_3 !== (c == 5)) $display("FAIL dbg_read lat3 ack c%0d: got %b want %b", c, dbg_ack_3, (c == 5)); else pass_cnt++;
            total++; if ({cpu_gnt, cpu_ack, cpu_gnt_3, cpu_ack_3} !== 4'b0) $display("FAIL dbg_read cpu side c%0d: got %b want 0", c, {cpu_gnt, cpu_ack, cpu_gnt_3, cpu_ack_3}); else pass_cnt++;
        end
        total++; if (dbg_rdata !== 8'hC3) $display("FAIL dbg_read rdata lat1: got %h want c3", dbg_rdata); else pass_cnt++;
        total++; if (dbg_rdata_3 !== 8'hC3) $display("FAIL dbg_read rdata lat3: got %h want c3", dbg_rdata_3); else pass_cnt++;
        total++; if (cpu_rdata !== exp_rd[0]) $display("FAIL dbg_read cpu_rdata: got %h want %h", cpu_rdata, exp_rd[0]); else pass_cnt++;
        total++; if (cpu_rdata_3 !== 8'h00) $display("FAIL dbg_read cpu_rdata_3: got %h want 00", cpu_rdata_3); else pass_cnt++;
        $display("xfer dbg_read: dbg RD addr=10 data=%h (lat1) %h (lat3)", dbg_rdata, dbg_rdata_3);
        exp_rd[1] = 8'hC3;
        lw_dbg    = 1'b1;
        step();
        en3 = 1'b0;
    endtask

    task automatic test_arbitration();
        bit w;
        string seq;
        seq = "";
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'hA0; cpu_wdata = 8'h11;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'hB0; dbg_wdata = 8'h22;
        for (int k = 0; k < 4; k++) begin
            w = pick(1'b1, 1'b1);
            xfer_check("arb", w, 1'b1, w ? 8'hB0 : 8'hA0, w ? 8'h22 : 8'h11, 1'b0);
            seq = {seq, w ? "dbg " : "cpu "};
            if (k == 3) begin
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
            step();
        end
        $display("arbitration order: %s", seq);
    endtask

    task automatic test_latch_inputs();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h77;
        step();
        total++; if ({cpu_gnt, mem_write} !== 2'b11) $display("FAIL latch c1 gnt/write: got %b want 11", {cpu_gnt, mem_write}); else pass_cnt++;
        total++; if (mem_address !== 8'h20) $display("FAIL latch c1 addr: got %h want 20", mem_address); else pass_cnt++;
        cpu_addr = 8'h21; cpu_req = 1'b0; cpu_wdata = 8'h99;
        step();
        total++; if (cpu_ack !== 1'b1) $display("FAIL latch ack: got %b want 1", cpu_ack); else pass_cnt++;
        total++; if (mem_address !== 8'h20) $display("FAIL latch c2 addr: got %h want 20", mem_address); else pass_cnt++;
        ref_mem[8'h20] = 8'h77;
        lw_dbg = 1'b0;
        $display("xfer latch: cpu WR addr=20 data=77");
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        xfer_check("latch_rd20", 1'b0, 1'b0, 8'h20, 8'h00, 1'b1);
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h21;
        xfer_check("latch_rd21", 1'b1, 1'b0, 8'h21, 8'h00, 1'b1);
        step();
    endtask

    task automatic test_reset_mid();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h44;
        step();
        dbg_req = 1'b0;
        step();
        #2;
        Reset = 1'b0;
        #1;
        total++; if ({dbg_gnt, dbg_ack, cpu_gnt, cpu_ack, mem_write, busy} !== 6'b0) $display("FAIL mid_reset ctl: got %b want 0", {dbg_gnt, dbg_ack, cpu_gnt, cpu_ack, mem_write, busy}); else pass_cnt++;
        total++; if ({mem_address, mem_from_bus, cpu_rdata, dbg_rdata} !== 32'h0) $display("FAIL mid_reset data: got %h want 0", {mem_address, mem_from_bus, cpu_rdata, dbg_rdata}); else pass_cnt++;
        lw_dbg = 1'b1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if ({dbg_ack, busy} !== 2'b00) $display("FAIL mid_reset held c%0d: got %b want 00", c, {dbg_ack, busy}); else pass_cnt++;
        end
        Reset = 1'b1;
        $display("xfer mid_reset: dbg RD addr=44 aborted");
        step();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h3C;
        xfer_check("after_reset", 1'b0, 1'b1, 8'h30, 8'h3C, 1'b1);
        step();
    endtask

    task automatic test_back_to_back();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h60; cpu_wdata = 8'hB5;
        for (int c = 1; c <= 13; c++) begin
            step();
            total++; if (cpu_ack !== (c <= 11 && c % 3 == 2)) $display("FAIL b2b ack c%0d: got %b want %b", c, cpu_ack, (c <= 11 && c % 3 == 2)); else pass_cnt++;
            total++; if (busy !== (c <= 11 && c % 3 != 0)) $display("FAIL b2b busy c%0d: got %b want %b", c, busy, (c <= 11 && c % 3 != 0)); else pass_cnt++;
            if (cpu_ack) $display("xfer b2b: cpu WR addr=60 data=b5 ack in cycle %0d", c);
            if (c == 11) cpu_req = 1'b0;
        end
        ref_mem[8'h60] = 8'hB5;
        lw_dbg = 1'b0;
    endtask

    task automatic test_random();
        bit         c_on, d_on, w, first;
        logic [7:0] ca, cd, da, dd;
        bit         cw, dw;
        int         mode;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            c_on = (mode != 1);
            d_on = (mode != 0);
            ca = 8'($urandom); cd = 8'($urandom); cw = 1'($urandom);
            da = 8'($urandom); dd = 8'($urandom); dw = 1'($urandom);
            cpu_req = c_on; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
            dbg_req = d_on; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
            first = 1'b1;
            while (c_on || d_on) begin
                w = pick(c_on, d_on);
                xfer_check($sformatf("rnd%0d", n), w, w ? dw : cw, w ? da : ca, w ? dd : cd, 1'b1);
                if (w) d_on = 1'b0;
                else   c_on = 1'b0;
                first = 1'b0;
                step();
            end
        end
    endtask

    initial begin
        Reset = 1'b0; en3 = 1'b0; load_mem = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            seed_mem[i] = 8'($urandom);
            ref_mem[i]  = seed_mem[i];
        end
        seed_mem[8'h10] = 8'hC3;
        ref_mem[8'h10]  = 8'hC3;

        test_reset();
        test_cpu_write();
        test_dbg_read_latency();
        test_arbitration();
        test_latch_inputs();
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
